// File: rtl/branch_resolver.sv
// Branch resolver: turns comparator flags + opcode into a taken decision, target PC, redirect pulse and a multi-cycle flush.
// Optional taken/not-taken statistics counters are enabled with `define BRANCH_RESOLVER_STATS_EN.
module branch_resolver #(
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_op,
  input  logic            cmp_l,
  input  logic            cmp_e,
  input  logic            cmp_g,
  input  logic            cmp_n,
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     imm,
  output logic            resolved_valid,
  output logic            taken,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic            flag_err
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [31:0]     taken_cnt,
  output logic [31:0]     nottaken_cnt
`endif
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              accept;
  logic              flags_ok;
  logic              bad;
  logic              cond;
  logic              take;
  logic signed [17:0] off;
  logic [PC_W-1:0]   target;

  // Ready and flush are pure functions of the registered state.
  assign br_ready = (state == IDLE);
  assign flush    = (state == FLUSH);
  assign accept   = br_valid & br_ready;

  assign flags_ok = (({cmp_l, cmp_e, cmp_g} == 3'b100) ||
                     ({cmp_l, cmp_e, cmp_g} == 3'b010) ||
                     ({cmp_l, cmp_e, cmp_g} == 3'b001)) && (cmp_n == ~cmp_e);
  assign bad      = (br_op != 3'd6) && !flags_ok;

  always_comb begin
    cond = 1'b0;
    case (br_op)
      3'd0: cond = cmp_e;
      3'd1: cond = cmp_n;
      3'd2: cond = cmp_l;
      3'd3: cond = cmp_g | cmp_e;
      3'd4: cond = cmp_g;
      3'd5: cond = cmp_l | cmp_e;
      3'd6: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign take   = cond & ~bad;
  // Word offset scaled to bytes; the signed cast sign-extends to PC_W, wrap is silent.
  assign off    = {imm, 2'b00};
  assign target = pc + PC_W'(4) + PC_W'(off);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      resolved_valid <= 1'b0;
      taken          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flag_err       <= 1'b0;
    end else begin
      resolved_valid <= accept;
      flag_err       <= accept & bad;
      redirect_valid <= accept & take;
      if (accept) taken <= take;
      if (accept && take) redirect_pc <= target;
      case (state)
        IDLE: if (accept && take) begin
          state <= FLUSH;
          cnt   <= 4'(FLUSH_CYCLES - 1);
        end
        FLUSH: if (cnt == 4'd0) state <= IDLE;
               else cnt <= cnt - 4'd1;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRANCH_RESOLVER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt    <= '0;
      nottaken_cnt <= '0;
    end else if (accept) begin
      if (take && taken_cnt != 32'hFFFF_FFFF) taken_cnt <= taken_cnt + 32'd1;
      if (!take && nottaken_cnt != 32'hFFFF_FFFF) nottaken_cnt <= nottaken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: two instances (FLUSH_CYCLES=2 and 4) checked every cycle against a behavioural model.
module tb_branch_resolver;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_valid = 1'b0, v4 = 1'b0;
  logic [2:0]  br_op = 3'd0;
  logic        cmp_l = 1'b0, cmp_e = 1'b1, cmp_g = 1'b0, cmp_n = 1'b0;
  logic [31:0] pc = '0;
  logic [15:0] imm = '0;

  logic        br_ready, resolved_valid, taken, redirect_valid, flush, flag_err;
  logic [31:0] redirect_pc;
  logic        rdy4, res4, tk4, rv4, fl4, err4;
  logic [31:0] rpc4;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] tcnt0, ncnt0, tcnt4, ncnt4;
`endif

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  branch_resolver u_dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready), .br_op(br_op),
    .cmp_l(cmp_l), .cmp_e(cmp_e), .cmp_g(cmp_g), .cmp_n(cmp_n), .pc(pc), .imm(imm),
    .resolved_valid(resolved_valid), .taken(taken), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .flag_err(flag_err)
`ifdef BRANCH_RESOLVER_STATS_EN
    , .taken_cnt(tcnt0), .nottaken_cnt(ncnt0)
`endif
  );

  branch_resolver #(.FLUSH_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .br_valid(v4), .br_ready(rdy4), .br_op(br_op),
    .cmp_l(cmp_l), .cmp_e(cmp_e), .cmp_g(cmp_g), .cmp_n(cmp_n), .pc(pc), .imm(imm),
    .resolved_valid(res4), .taken(tk4), .redirect_valid(rv4),
    .redirect_pc(rpc4), .flush(fl4), .flag_err(err4)
`ifdef BRANCH_RESOLVER_STATS_EN
    , .taken_cnt(tcnt4), .nottaken_cnt(ncnt4)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: rem = flush cycles still to come, including the current one.
  int          fcs[2] = '{2, 4};
  int          m_rem[2] = '{0, 0};
  bit          m_res[2], m_tk[2], m_rv[2], m_err[2];
  logic [31:0] m_rpc[2] = '{32'h0, 32'h0};
  int          m_tc[2] = '{0, 0};
  int          m_nc[2] = '{0, 0};

  function automatic void decide(input logic [2:0] op, input bit l, e, g, n,
                                 output bit tk, output bit er);
    bit ok;
    ok = ((int'(l) + int'(e) + int'(g)) == 1) && (n == !e);
    case (op)
      3'd0: tk = e;
      3'd1: tk = n;
      3'd2: tk = l;
      3'd3: tk = g || e;
      3'd4: tk = g;
      3'd5: tk = l || e;
      3'd6: tk = 1'b1;
      default: tk = 1'b0;
    endcase
    er = (op != 3'd6) && !ok;
    if (er) tk = 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_rem[k] = 0; m_res[k] = 0; m_tk[k] = 0; m_rv[k] = 0; m_err[k] = 0;
        m_rpc[k] = 0; m_tc[k] = 0; m_nc[k] = 0;
      end else begin
        bit acc, tk, er;
        int off;
        acc = ((k == 0) ? br_valid : v4) && (m_rem[k] == 0);
        decide(br_op, cmp_l, cmp_e, cmp_g, cmp_n, tk, er);
        off = $signed(imm);
        if (acc && tk) m_rem[k] = fcs[k];
        else if (m_rem[k] > 0) m_rem[k]--;
        m_res[k] = acc;
        m_err[k] = acc && er;
        m_rv[k]  = acc && tk;
        if (acc) m_tk[k] = tk;
        if (acc && tk) m_rpc[k] = pc + 32'd4 + 32'(off * 4);
        if (acc && tk) m_tc[k]++;
        if (acc && !tk) m_nc[k]++;
      end
    end
  end

  always @(negedge clk) begin
    chk("m0_ready", {31'd0, br_ready}, {31'd0, m_rem[0] == 0});
    chk("m0_flush", {31'd0, flush}, {31'd0, m_rem[0] != 0});
    chk("m0_res", {31'd0, resolved_valid}, {31'd0, m_res[0]});
    chk("m0_taken", {31'd0, taken}, {31'd0, m_tk[0]});
    chk("m0_rv", {31'd0, redirect_valid}, {31'd0, m_rv[0]});
    chk("m0_rpc", redirect_pc, m_rpc[0]);
    chk("m0_err", {31'd0, flag_err}, {31'd0, m_err[0]});
    chk("m4_ready", {31'd0, rdy4}, {31'd0, m_rem[1] == 0});
    chk("m4_flush", {31'd0, fl4}, {31'd0, m_rem[1] != 0});
    chk("m4_res", {31'd0, res4}, {31'd0, m_res[1]});
    chk("m4_taken", {31'd0, tk4}, {31'd0, m_tk[1]});
    chk("m4_rv", {31'd0, rv4}, {31'd0, m_rv[1]});
    chk("m4_rpc", rpc4, m_rpc[1]);
    chk("m4_err", {31'd0, err4}, {31'd0, m_err[1]});
`ifdef BRANCH_RESOLVER_STATS_EN
    chk("m0_tcnt", tcnt0, 32'(m_tc[0]));
    chk("m0_ncnt", ncnt0, 32'(m_nc[0]));
    chk("m4_tcnt", tcnt4, 32'(m_tc[1]));
    chk("m4_ncnt", ncnt4, 32'(m_nc[1]));
`endif
  end

  // Called right after a rising edge; returns at the accepting edge with the number of stalled cycles.
  task automatic issue(input bit use4, input logic [2:0] op, input bit l, e, g, n,
                       input logic [31:0] pcv, input logic [15:0] immv, output int waits);
    bit r, done;
    #2;
    br_op = op; cmp_l = l; cmp_e = e; cmp_g = g; cmp_n = n; pc = pcv; imm = immv;
    if (use4) v4 = 1'b1; else br_valid = 1'b1;
    done = 0; waits = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      r = use4 ? rdy4 : br_ready;
      @(posedge clk);
      if (r) done = 1; else waits++;
    end
    if (!done) begin
      nchk++; nerr++;
      $display("FAIL accept_timeout actual=stalled required=accepted t=%0t", $time);
    end
  endtask

  task automatic idle();
    #2;
    br_valid = 1'b0; v4 = 1'b0;
  endtask

  typedef struct { logic [2:0] op; bit l, e, g, n; logic [31:0] pcv; logic [15:0] immv; } vec_t;
  vec_t tbl[6];

  initial begin
    int w;
    tbl[0] = '{3'd7, 0, 1, 0, 0, 32'h0000_3000, 16'h0005};  // reserved: not taken, no error
    tbl[1] = '{3'd3, 0, 0, 1, 1, 32'h0000_4000, 16'h0002};  // BGE via G: taken
    tbl[2] = '{3'd4, 0, 1, 0, 0, 32'h0000_5000, 16'h0001};  // BGT with E: not taken
    tbl[3] = '{3'd5, 1, 0, 0, 1, 32'h0000_6000, 16'h8000};  // BLE via L: taken, max negative offset
    tbl[4] = '{3'd1, 0, 1, 0, 1, 32'h0000_7000, 16'h0001};  // N disagrees with E: error
    tbl[5] = '{3'd6, 1, 1, 1, 1, 32'hFFFF_FFF8, 16'h0001};  // BAL ignores garbage flags, wraps

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, br_ready}, 32'd1);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    @(posedge clk);

    // BEQ taken
    issue(0, 3'd0, 0, 1, 0, 0, 32'h0040_0000, 16'h0003, w);
    idle();
    @(negedge clk);
    chk("beq_res", {31'd0, resolved_valid}, 32'd1);
    chk("beq_taken", {31'd0, taken}, 32'd1);
    chk("beq_rv", {31'd0, redirect_valid}, 32'd1);
    chk("beq_rpc", redirect_pc, 32'h0040_0010);
    chk("beq_flush1", {31'd0, flush}, 32'd1);
    chk("beq_ready1", {31'd0, br_ready}, 32'd0);
    @(negedge clk);
    chk("beq_flush2", {31'd0, flush}, 32'd1);
    chk("beq_rv2", {31'd0, redirect_valid}, 32'd0);
    @(negedge clk);
    chk("beq_flush3", {31'd0, flush}, 32'd0);
    chk("beq_ready3", {31'd0, br_ready}, 32'd1);
    @(posedge clk);

    // BLT not-taken, back to back
    for (int i = 0; i < 3; i++) begin
      issue(0, 3'd2, 0, 0, 1, 1, 32'h0000_1000 + 32'(i * 4), 16'h0007, w);
      chk("blt_nostall", 32'(w), 32'd0);
    end
    idle();
    @(negedge clk);
    chk("blt_res", {31'd0, resolved_valid}, 32'd1);
    chk("blt_taken", {31'd0, taken}, 32'd0);
    chk("blt_flush", {31'd0, flush}, 32'd0);
    @(posedge clk);

    // BAL with negative offset wrapping below zero
    issue(0, 3'd6, 0, 0, 1, 1, 32'h0000_0000, 16'hFFFE, w);
    idle();
    @(negedge clk);
    chk("bal_rpc", redirect_pc, 32'hFFFF_FFFC);
    chk("bal_taken", {31'd0, taken}, 32'd1);
    repeat (3) @(posedge clk);

    // Taken branch followed by a request held through the flush
    issue(0, 3'd0, 0, 1, 0, 0, 32'h0000_1000, 16'h0010, w);
    issue(0, 3'd1, 1, 0, 0, 1, 32'h0000_2000, 16'h0001, w);
    chk("held_wait", 32'(w), 32'd2);
    idle();
    @(negedge clk);
    chk("held_rv", {31'd0, redirect_valid}, 32'd1);
    chk("held_rpc", redirect_pc, 32'h0000_2008);
    repeat (3) @(posedge clk);

    // Inconsistent flags: L and E both set
    issue(0, 3'd0, 1, 1, 0, 0, 32'h0000_8000, 16'h0004, w);
    idle();
    @(negedge clk);
    chk("bad_taken", {31'd0, taken}, 32'd0);
    chk("bad_err", {31'd0, flag_err}, 32'd1);
    chk("bad_flush", {31'd0, flush}, 32'd0);
    chk("bad_rpc_hold", redirect_pc, 32'h0000_2008);
    @(negedge clk);
    chk("bad_err_pulse", {31'd0, flag_err}, 32'd0);
    @(posedge clk);

    foreach (tbl[i]) issue(0, tbl[i].op, tbl[i].l, tbl[i].e, tbl[i].g, tbl[i].n, tbl[i].pcv, tbl[i].immv, w);
    idle();
    @(negedge clk);
    chk("tbl_last_rpc", redirect_pc, 32'h0000_0000);
    repeat (4) @(posedge clk);

    // Reset in the second flush cycle of the FLUSH_CYCLES=4 instance
    issue(1, 3'd6, 0, 1, 0, 0, 32'h0000_0100, 16'h0000, w);
    idle();
    @(negedge clk);
    chk("r4_flush1", {31'd0, fl4}, 32'd1);
    chk("r4_rpc", rpc4, 32'h0000_0104);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("r4_flush_abort", {31'd0, fl4}, 32'd0);
    chk("r4_rv_abort", {31'd0, rv4}, 32'd0);
`ifdef BRANCH_RESOLVER_STATS_EN
    chk("r4_tcnt0", tcnt4, 32'd0);
    chk("r4_ncnt0", ncnt0, 32'd0);
`endif
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("r4_ready", {31'd0, rdy4}, 32'd1);
    chk("r4_flush_after", {31'd0, fl4}, 32'd0);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
